// File: rtl/spike_event_fifo.sv
// spike_event_fifo: captures the two neuron spike strobes, tags each spike
// with its neuron id (and optionally a timestep stamp), buffers the events
// in a small FIFO and drains them as a byte-wide valid/ready stream.
//
// Build option: define SPIKE_EVT_TS_EN to include the timestep counter and
// per-neuron stamp registers. Without it, tick is ignored and the low seven
// bits of every event byte are zero.
//
// Handshake: a head event is transferred on every rising clk edge where
// evt_valid and evt_ready are both high. evt_valid does not depend on
// evt_ready. evt_data is the head entry (first-word-fall-through) and reads
// as zero while the FIFO is empty.
module spike_event_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic                     tick,
    input  logic [1:0]               spike_in,
    output logic [7:0]               evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [1:0]    r_pend;
    logic [7:0]    r_drop_cnt;
    logic          r_overflow;

    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_sel;
    logic [1:0]    w_cap;
    logic [1:0]    w_grant;
    logic [1:0]    w_drop;
    logic [1:0]    w_drop_sum;
    logic [8:0]    w_drop_next;
    logic [TS_W-1:0] w_entry_ts;
    logic [7:0]    w_entry;

    assign w_pop   = evt_valid & evt_ready;
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    // Neuron 0 always wins; neuron 1 is selected only when neuron 0 is idle.
    assign w_sel   = ~r_pend[0];
    // A slot is free after this cycle's pop, so a full FIFO still accepts a push
    // when the head leaves on the same edge.
    assign w_push  = (|r_pend) & (~w_full | w_pop);
    assign w_cap   = {2{ena}} & spike_in;
    assign w_grant = {w_push & w_sel, w_push & ~w_sel};
    // A spike is lost only if its neuron is already pending and that pending
    // event is not leaving for the FIFO on this edge.
    assign w_drop  = w_cap & r_pend & ~w_grant;
    assign w_drop_sum  = {1'b0, w_drop[0]} + {1'b0, w_drop[1]};
    assign w_drop_next = {1'b0, r_drop_cnt} + 9'(w_drop_sum);

`ifdef SPIKE_EVT_TS_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_pend_ts [2];

    assign w_entry_ts = r_pend_ts[w_sel];

    // Timestep counter; wraps naturally at 2^TS_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (clr) begin
            r_ts <= '0;
        end else if (ena && tick) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Latch the pre-increment stamp whenever a neuron's pending slot is (re)loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_ts[0] <= '0;
            r_pend_ts[1] <= '0;
        end else if (clr) begin
            r_pend_ts[0] <= '0;
            r_pend_ts[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_cap[i] && (w_grant[i] || !r_pend[i])) begin
                    r_pend_ts[i] <= r_ts;
                end
            end
        end
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = tick;
    assign w_entry_ts    = '0;
`endif

    assign w_entry = {w_sel, 7'(w_entry_ts)};

    // Per-neuron pending flags: set by a capture, cleared when written to the
    // FIFO unless a fresh spike re-arms the same neuron on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (clr) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i]) begin
                    r_pend[i] <= w_cap[i];
                end else if (w_cap[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    // Event storage; contents are only observed through the valid head slot.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_drop_cnt <= w_drop_next[8] ? 8'hFF : w_drop_next[7:0];
            r_overflow <= 1'b1;
        end
    end

    assign evt_valid  = (r_level != '0);
    assign evt_data   = evt_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop_cnt;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed bench for spike_event_fifo (DEPTH=8, TS_W=6).
module tb_spike_event_fifo;

`ifdef SPIKE_EVT_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       tick;
    logic [1:0] spike_in;
    logic [7:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] fifo_level;
    logic [7:0] drop_cnt;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    spike_event_fifo #(.DEPTH(8), .TS_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .tick(tick),
        .spike_in(spike_in), .evt_data(evt_data), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    // Clock
    always #5 clk = ~clk;

    // Expected event byte for a neuron id and stamp in the current build.
    function automatic logic [7:0] ev(input bit id, input int ts);
        logic [6:0] low;
        low = TS_ON ? 7'(ts) : 7'd0;
        return {id, low};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", evt_data); end
    endtask

    task automatic test_single();
        clear();
        ticks(5);
        evt_ready = 1'b1;
        spike_in = 2'b01; step(); spike_in = 2'b00;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_lat_n: got %b want 0", evt_valid); end
        step();
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        checks++; if (evt_data !== ev(0, 5)) begin errors++; $display("FAIL single_data: got %h want %h", evt_data, ev(0, 5)); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_pop: got %0d want 0", fifo_level); end
        evt_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        clear();
        ticks(9);
        spike_in = 2'b11; step(); spike_in = 2'b00;
        step();
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL simul_level1: got %0d want 1", fifo_level); end
        checks++; if (evt_data !== ev(0, 9)) begin errors++; $display("FAIL simul_first: got %h want %h", evt_data, ev(0, 9)); end
        step();
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL simul_level2: got %0d want 2", fifo_level); end
        evt_ready = 1'b1; step();
        checks++; if (evt_data !== ev(1, 9)) begin errors++; $display("FAIL simul_second: got %h want %h", evt_data, ev(1, 9)); end
        step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL simul_drain: got %0d want 0", fifo_level); end
        evt_ready = 1'b0;
    endtask

    task automatic test_full();
        clear();
        for (int k = 0; k < 8; k++) begin
            spike_in = 2'b01; step(); spike_in = 2'b00; step();
        end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", fifo_level); end
        spike_in = 2'b01; step(); spike_in = 2'b00; step();
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL full_pending_nodrop: got %0d want 0", drop_cnt); end
        spike_in = 2'b01; step(); spike_in = 2'b00;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_drop: got %0d want 1", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b want 1", overflow); end
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_pushpop: got %0d want 8", fifo_level); end
        step();
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_pend_clear: got %0d want 8", fifo_level); end
        checks++; if (evt_data !== ev(0, 0)) begin errors++; $display("FAIL full_head: got %h want %h", evt_data, ev(0, 0)); end
        evt_ready = 1'b1; repeat (8) step(); evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got level %0d valid %b want 0 0", fifo_level, evt_valid); end
        step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL full_empty_stays: got %0d want 0", fifo_level); end
    endtask

    task automatic test_enable();
        clear();
        ena = 1'b0; spike_in = 2'b01; tick = 1'b1; step();
        spike_in = 2'b00; tick = 1'b0; step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ena_nocap: got %0d want 0", fifo_level); end
        ena = 1'b1; spike_in = 2'b10; step(); spike_in = 2'b00; step();
        checks++; if (evt_data !== ev(1, 0)) begin errors++; $display("FAIL ena_ts_frozen: got %h want %h", evt_data, ev(1, 0)); end
        spike_in = 2'b01; step(); spike_in = 2'b00; ena = 1'b0; step();
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL ena_pend_writes: got %0d want 2", fifo_level); end
        evt_ready = 1'b1; step(); step(); evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ena_pop: got %0d want 0", fifo_level); end
        ena = 1'b1;
    endtask

    task automatic test_ts_wrap();
        clear();
        ticks(63);
        spike_in = 2'b01; tick = 1'b1; step();
        spike_in = 2'b00; tick = 1'b0; step();
        checks++; if (evt_data !== ev(0, 63)) begin errors++; $display("FAIL wrap_pre: got %h want %h", evt_data, ev(0, 63)); end
        spike_in = 2'b01; step(); spike_in = 2'b00; step();
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL wrap_level: got %0d want 2", fifo_level); end
        evt_ready = 1'b1; step();
        checks++; if (evt_data !== ev(0, 0)) begin errors++; $display("FAIL wrap_zero: got %h want %h", evt_data, ev(0, 0)); end
        step(); evt_ready = 1'b0;
    endtask

    task automatic test_saturation();
        clear();
        spike_in = 2'b11;
        repeat (9) step();
        checks++; if (drop_cnt !== 8'd8 || fifo_level !== 4'd8) begin errors++; $display("FAIL sat_fill: got drop %0d level %0d want 8 8", drop_cnt, fifo_level); end
        repeat (11) step();
        checks++; if (drop_cnt !== 8'd30) begin errors++; $display("FAIL sat_double: got %0d want 30", drop_cnt); end
        repeat (112) step();
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", drop_cnt); end
        step();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_clip: got %0d want 255", drop_cnt); end
        repeat (50) step();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
        spike_in = 2'b00;
        clear();
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL sat_clr_drop: got %0d %b want 0 0", drop_cnt, overflow); end
        checks++; if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL sat_clr_fifo: got %b %0d want 0 0", evt_valid, fifo_level); end
        step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL sat_clr_pend: got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        clear();
        spike_in = 2'b11; repeat (4) step(); spike_in = 2'b00;
        checks++; if (fifo_level !== 4'd3 || drop_cnt !== 8'd3) begin errors++; $display("FAIL mid_setup: got level %0d drop %0d want 3 3", fifo_level, drop_cnt); end
        #2; rst_n = 1'b0; #1;
        checks++; if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL mid_fifo: got %b %0d want 0 0", evt_valid, fifo_level); end
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_drop: got %0d %b want 0 0", drop_cnt, overflow); end
        rst_n = 1'b1;
        step(); step();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_pend: got %0d want 0", fifo_level); end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; tick = 1'b0;
        spike_in = 2'b00; evt_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_enable();
        test_ts_wrap();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
